// File: rtl/fft_r4_bf_pipe.sv
// Pipelined radix-4 DIF butterfly: input capture, sum, twiddle multiply, round/scale/limit.
// Optional macro FFT_BF_SAT_EN selects saturation plus a sticky ovf flag instead of wrap.
module fft_r4_bf_pipe #(
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int SCALE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          inv,
    input  logic [DW-1:0] ar, ai, br, bi, cr, ci, dr, di,
    input  logic [TW-1:0] w1r, w1i, w2r, w2i, w3r, w3i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i,
    output logic          ovf,
    input  logic          clr_ovf
);
    localparam int XW = DW + 2;
    localparam int PW = DW + TW + 3;
    localparam int RW = PW + 1;
    localparam int SH = TW - 1 + SCALE;
    localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SH - 1);
`ifdef FFT_BF_SAT_EN
    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
`endif

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [DW-1:0]        in_dr [4], in_di [4];
    logic [TW-1:0]        in_wr [3], in_wi [3];
    logic [DW-1:0]        s0_dr_reg [4], s0_di_reg [4];
    logic signed [TW-1:0] s0_wr_reg [3], s0_wi_reg [3];
    logic                 s0_inv_reg, s0_v_reg;
    logic signed [XW-1:0] xr_next [4], xi_next [4];
    logic signed [XW-1:0] s1_xr_reg [4], s1_xi_reg [4];
    logic signed [TW-1:0] s1_wr_reg [3], s1_wi_reg [3];
    logic                 s1_v_reg;
    logic signed [PW-1:0] yr_next [4], yi_next [4];
    logic signed [PW-1:0] s2_yr_reg [4], s2_yi_reg [4];
    logic                 s2_v_reg;
    logic [DW-1:0]        or_next [4], oi_next [4];
    logic [DW-1:0]        s3_or_reg [4], s3_oi_reg [4];
    logic                 s3_v_reg;
    logic [7:0]           oor;

    assign in_dr = '{ar, br, cr, dr};
    assign in_di = '{ai, bi, ci, di};
    assign in_wr = '{w1r, w2r, w3r};
    assign in_wi = '{w1i, w2i, w3i};

    // Stage 1: radix-4 sums at DW+2 bits; inverse mode swaps the X1/X3 rotations.
    logic signed [XW-1:0] er [4], ei [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_ext
        assign er[gi] = {{2{s0_dr_reg[gi][DW-1]}}, s0_dr_reg[gi]};
        assign ei[gi] = {{2{s0_di_reg[gi][DW-1]}}, s0_di_reg[gi]};
    end

    logic signed [XW-1:0] sac_r, sac_i, dac_r, dac_i, sbd_r, sbd_i, dbd_r, dbd_i;
    logic signed [XW-1:0] p_r, p_i, n_r, n_i;
    assign sac_r = er[0] + er[2];
    assign sac_i = ei[0] + ei[2];
    assign dac_r = er[0] - er[2];
    assign dac_i = ei[0] - ei[2];
    assign sbd_r = er[1] + er[3];
    assign sbd_i = ei[1] + ei[3];
    assign dbd_r = er[1] - er[3];
    assign dbd_i = ei[1] - ei[3];
    assign p_r   = dac_r + dbd_i;
    assign p_i   = dac_i - dbd_r;
    assign n_r   = dac_r - dbd_i;
    assign n_i   = dac_i + dbd_r;

    assign xr_next[0] = sac_r + sbd_r;
    assign xi_next[0] = sac_i + sbd_i;
    assign xr_next[2] = sac_r - sbd_r;
    assign xi_next[2] = sac_i - sbd_i;
    assign xr_next[1] = s0_inv_reg ? n_r : p_r;
    assign xi_next[1] = s0_inv_reg ? n_i : p_i;
    assign xr_next[3] = s0_inv_reg ? p_r : n_r;
    assign xi_next[3] = s0_inv_reg ? p_i : n_i;

    // Stage 2: X0 is scaled by unity in Q1.(TW-1) so all four lanes share one rounding path.
    for (genvar gi = 0; gi < 4; gi++) begin : g_mul
        if (gi == 0) begin : g_unity
            assign yr_next[0] = {{(PW-XW){s1_xr_reg[0][XW-1]}}, s1_xr_reg[0]} <<< (TW - 1);
            assign yi_next[0] = {{(PW-XW){s1_xi_reg[0][XW-1]}}, s1_xi_reg[0]} <<< (TW - 1);
        end else begin : g_twiddle
            logic signed [XW+TW-1:0] p_rr, p_ii, p_ri, p_ir;
            assign p_rr = s1_xr_reg[gi] * s1_wr_reg[gi-1];
            assign p_ii = s1_xi_reg[gi] * s1_wi_reg[gi-1];
            assign p_ri = s1_xr_reg[gi] * s1_wi_reg[gi-1];
            assign p_ir = s1_xi_reg[gi] * s1_wr_reg[gi-1];
            assign yr_next[gi] = {p_rr[XW+TW-1], p_rr} - {p_ii[XW+TW-1], p_ii};
            assign yi_next[gi] = {p_ri[XW+TW-1], p_ri} + {p_ir[XW+TW-1], p_ir};
        end
    end

    // Returns {out_of_range, limited_value} after round-half-up and shift by SH.
    function automatic logic [DW:0] round_limit(input logic signed [PW-1:0] y);
        logic signed [RW-1:0] sum;
        logic signed [RW-1:0] shr;
        logic                 fit;
        sum = {y[PW-1], y} + HALF;
        shr = sum >>> SH;
        fit = (shr[RW-1:DW-1] == {(RW-DW+1){shr[DW-1]}});
`ifdef FFT_BF_SAT_EN
        if (!fit) return {1'b1, (shr[RW-1] ? MINV : MAXV)};
`endif
        return {!fit, shr[DW-1:0]};
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
        logic [DW:0] rl_r, rl_i;
        assign rl_r        = round_limit(s2_yr_reg[gi]);
        assign rl_i        = round_limit(s2_yi_reg[gi]);
        assign or_next[gi] = rl_r[DW-1:0];
        assign oi_next[gi] = rl_i[DW-1:0];
        assign oor[gi]     = rl_r[DW];
        assign oor[gi+4]   = rl_i[DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v_reg   <= 1'b0;
            s0_inv_reg <= 1'b0;
            s1_v_reg   <= 1'b0;
            s2_v_reg   <= 1'b0;
            s3_v_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s0_dr_reg[i] <= '0;
                s0_di_reg[i] <= '0;
                s1_xr_reg[i] <= '0;
                s1_xi_reg[i] <= '0;
                s2_yr_reg[i] <= '0;
                s2_yi_reg[i] <= '0;
                s3_or_reg[i] <= '0;
                s3_oi_reg[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                s0_wr_reg[i] <= '0;
                s0_wi_reg[i] <= '0;
                s1_wr_reg[i] <= '0;
                s1_wi_reg[i] <= '0;
            end
        end else if (adv) begin
            s0_v_reg   <= in_valid;
            s0_inv_reg <= inv;
            s1_v_reg   <= s0_v_reg;
            s2_v_reg   <= s1_v_reg;
            s3_v_reg   <= s2_v_reg;
            for (int i = 0; i < 4; i++) begin
                s0_dr_reg[i] <= in_dr[i];
                s0_di_reg[i] <= in_di[i];
                s1_xr_reg[i] <= xr_next[i];
                s1_xi_reg[i] <= xi_next[i];
                s2_yr_reg[i] <= yr_next[i];
                s2_yi_reg[i] <= yi_next[i];
                s3_or_reg[i] <= or_next[i];
                s3_oi_reg[i] <= oi_next[i];
            end
            for (int i = 0; i < 3; i++) begin
                s0_wr_reg[i] <= in_wr[i];
                s0_wi_reg[i] <= in_wi[i];
                s1_wr_reg[i] <= s0_wr_reg[i];
                s1_wi_reg[i] <= s0_wi_reg[i];
            end
        end
    end

`ifdef FFT_BF_SAT_EN
    logic ovf_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        ovf_reg <= 1'b0;
        else if (adv && s2_v_reg && |oor) ovf_reg <= 1'b1;
        else if (clr_ovf)                  ovf_reg <= 1'b0;
    end
    assign ovf = ovf_reg;
`else
    logic unused_ovf_src;
    assign unused_ovf_src = ^{clr_ovf, oor};
    assign ovf            = 1'b0;
`endif

    assign out_valid = s3_v_reg;
    assign out0r = s3_or_reg[0];
    assign out0i = s3_oi_reg[0];
    assign out1r = s3_or_reg[1];
    assign out1i = s3_oi_reg[1];
    assign out2r = s3_or_reg[2];
    assign out2i = s3_oi_reg[2];
    assign out3r = s3_or_reg[3];
    assign out3i = s3_oi_reg[3];
endmodule

// File: tb/tb_fft_r4_bf_pipe.sv
// Directed bench for fft_r4_bf_pipe: SCALE=2 main instance plus a SCALE=0 instance for overflow.
module tb_fft_r4_bf_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic in_valid = 1'b0, inv = 1'b0, out_ready = 1'b1, clr_ovf = 1'b0;
    logic signed [15:0] ar, ai, br, bi, cr, ci, dr, di;
    logic signed [15:0] w1r, w1i, w2r, w2i, w3r, w3i;
    logic in_ready, out_valid, ovf;
    logic signed [15:0] out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i;
    logic in_ready_z, out_valid_z, ovf_z;
    logic signed [15:0] z0r, z0i, z1r, z1i, z2r, z2i, z3r, z3i;
    int n_vec = 0;
    int n_err = 0;

    fft_r4_bf_pipe #(.DW(16), .TW(16), .SCALE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
        .w1r(w1r), .w1i(w1i), .w2r(w2r), .w2i(w2i), .w3r(w3r), .w3i(w3i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0r(out0r), .out0i(out0i), .out1r(out1r), .out1i(out1i),
        .out2r(out2r), .out2i(out2i), .out3r(out3r), .out3i(out3i),
        .ovf(ovf), .clr_ovf(clr_ovf)
    );

    fft_r4_bf_pipe #(.DW(16), .TW(16), .SCALE(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z), .inv(inv),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .cr(cr), .ci(ci), .dr(dr), .di(di),
        .w1r(w1r), .w1i(w1i), .w2r(w2r), .w2i(w2i), .w3r(w3r), .w3i(w3i),
        .out_valid(out_valid_z), .out_ready(out_ready),
        .out0r(z0r), .out0i(z0i), .out1r(z1r), .out1i(z1i),
        .out2r(z2r), .out2i(z2i), .out3r(z3r), .out3i(z3i),
        .ovf(ovf_z), .clr_ovf(clr_ovf)
    );

    task automatic set_in(input int a_r, input int a_i, input int b_r, input int b_i,
                          input int c_r, input int c_i, input int d_r, input int d_i,
                          input int t1r, input int t1i, input logic md);
        ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r); bi = 16'(b_i);
        cr = 16'(c_r); ci = 16'(c_i); dr = 16'(d_r); di = 16'(d_i);
        w1r = 16'(t1r); w1i = 16'(t1i);
        w2r = 16'sd32767; w2i = 16'sd0; w3r = 16'sd32767; w3i = 16'sd0;
        inv = md;
    endtask

    // Present one beat with out_ready high and wait (bounded) for it to emerge.
    task automatic push_one(output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32767, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out0r !== 16'sd0 || out3i !== 16'sd0) begin n_err++; $display("FAIL reset_outputs: got %0d/%0d want 0/0", out0r, out3i); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask

    task automatic test_dc();
        int lat;
        set_in(1000, 0, 1000, 0, 1000, 0, 1000, 0, 32767, 0, 1'b0);
        push_one(lat);
        $display("dc: lat=%0d out0=%0d,%0d out1=%0d out2=%0d out3=%0d", lat, out0r, out0i, out1r, out2r, out3r);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL dc_latency: got %0d want 3", lat); end
        n_vec++; if (out0r !== 16'sd1000 || out0i !== 16'sd0) begin n_err++; $display("FAIL dc_out0: got %0d,%0d want 1000,0", out0r, out0i); end
        n_vec++; if (out1r !== 16'sd0 || out1i !== 16'sd0) begin n_err++; $display("FAIL dc_out1: got %0d,%0d want 0,0", out1r, out1i); end
        n_vec++; if (out2r !== 16'sd0 || out3r !== 16'sd0) begin n_err++; $display("FAIL dc_out23: got %0d,%0d want 0,0", out2r, out3r); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL dc_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_impulse();
        int lat;
        set_in(4000, 0, 0, 0, 0, 0, 0, 0, 0, -32767, 1'b0);
        push_one(lat);
        $display("impulse: lat=%0d out0=%0d out1=%0d,%0d out2=%0d out3=%0d", lat, out0r, out1r, out1i, out2r, out3r);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL imp_latency: got %0d want 3", lat); end
        n_vec++; if (out0r !== 16'sd1000) begin n_err++; $display("FAIL imp_out0r: got %0d want 1000", out0r); end
        n_vec++; if (out1r !== 16'sd0 || out1i !== -16'sd1000) begin n_err++; $display("FAIL imp_out1: got %0d,%0d want 0,-1000", out1r, out1i); end
        n_vec++; if (out2r !== 16'sd1000) begin n_err++; $display("FAIL imp_out2r: got %0d want 1000", out2r); end
        n_vec++; if (out3r !== 16'sd1000) begin n_err++; $display("FAIL imp_out3r: got %0d want 1000", out3r); end
    endtask

    task automatic test_mode();
        int lat;
        set_in(0, 0, 0, 4000, 0, 0, 0, 0, 32767, 0, 1'b0);
        push_one(lat);
        $display("mode fwd: out1r=%0d out3r=%0d", out1r, out3r);
        n_vec++; if (out1r !== 16'sd1000 || out3r !== -16'sd1000) begin n_err++; $display("FAIL mode_fwd: got %0d,%0d want 1000,-1000", out1r, out3r); end
        n_vec++; if (out0i !== 16'sd1000) begin n_err++; $display("FAIL mode_fwd_out0i: got %0d want 1000", out0i); end
        set_in(0, 0, 0, 4000, 0, 0, 0, 0, 32767, 0, 1'b1);
        push_one(lat);
        $display("mode inv: out1r=%0d out3r=%0d", out1r, out3r);
        n_vec++; if (out1r !== -16'sd1000 || out3r !== 16'sd1000) begin n_err++; $display("FAIL mode_inv: got %0d,%0d want -1000,1000", out1r, out3r); end
    endtask

    task automatic test_overflow();
        int lat;
        logic signed [15:0] exp_z0r;
        logic exp_ovf;
`ifdef FFT_BF_SAT_EN
        exp_z0r = 16'sd32767;
        exp_ovf = 1'b1;
`else
        exp_z0r = 16'sd14464;
        exp_ovf = 1'b0;
`endif
        set_in(20000, 0, 20000, 0, 20000, 0, 20000, 0, 32767, 0, 1'b0);
        push_one(lat);
        $display("overflow: z0r=%0d ovf=%b out0r=%0d", z0r, ovf_z, out0r);
        n_vec++; if (z0r !== exp_z0r) begin n_err++; $display("FAIL ovf_z0r: got %0d want %0d", z0r, exp_z0r); end
        n_vec++; if (ovf_z !== exp_ovf) begin n_err++; $display("FAIL ovf_flag: got %b want %b", ovf_z, exp_ovf); end
        n_vec++; if (out0r !== 16'sd20000) begin n_err++; $display("FAIL ovf_scaled_out0r: got %0d want 20000", out0r); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ovf_z !== exp_ovf) begin n_err++; $display("FAIL ovf_sticky: got %b want %b", ovf_z, exp_ovf); end
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        n_vec++; if (ovf_z !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf_z); end
        // Clear held across the setting edge: set must win.
        clr_ovf = 1'b1;
        push_one(lat);
        clr_ovf = 1'b0;
        n_vec++; if (ovf_z !== exp_ovf) begin n_err++; $display("FAIL ovf_set_wins: got %b want %b", ovf_z, exp_ovf); end
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0, extra = 0;
        logic hold = 1'b0;
        logic signed [15:0] h0r = '0, h0i = '0;
        while (got < 8 && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            if (sent < 8) begin
                set_in(400 * (sent + 1), 40 * (sent + 1), 0, 0, 0, 0, 0, 0, 32767, 0, 1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (hold) begin
                n_vec++;
                if (out_valid !== 1'b1 || out0r !== h0r || out0i !== h0i) begin
                    n_err++; $display("FAIL stall_hold: got v=%b %0d,%0d want v=1 %0d,%0d", out_valid, out0r, out0i, h0r, h0i);
                end
            end
            if (out_valid && !out_ready) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            end
            if (out_valid && out_ready) begin
                got++;
                $display("b2b beat %0d: out0=%0d,%0d out3r=%0d", got, out0r, out0i, out3r);
                n_vec++;
                if (out0r !== 16'(100 * got) || out0i !== 16'(10 * got) || out3r !== 16'(100 * got)) begin
                    n_err++; $display("FAIL b2b_beat%0d: got %0d,%0d,%0d want %0d,%0d,%0d", got, out0r, out0i, out3r, 100 * got, 10 * got, 100 * got);
                end
            end
            if (in_valid && in_ready) sent++;
            hold = out_valid && !out_ready;
            h0r  = out0r;
            h0i  = out0i;
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++; if (got != 8) begin n_err++; $display("FAIL b2b_count: got %0d beats want 8", got); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        n_vec++; if (extra != 0) begin n_err++; $display("FAIL b2b_duplicates: got %0d extra beats want 0", extra); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        int lat;
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_in(400 * k, 40 * k, 0, 0, 0, 0, 0, 0, 32767, 0, 1'b0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out0r !== 16'sd100) begin n_err++; $display("FAIL mid_first_beat: got v=%b %0d want v=1 100", out_valid, out0r); end
        rst_n = 1'b0;
        #1;
        $display("reset mid-stream: out_valid=%b out0r=%0d", out_valid, out0r);
        n_vec++; if (out_valid !== 1'b0 || out0r !== 16'sd0 || out0i !== 16'sd0) begin n_err++; $display("FAIL mid_reset_clear: got v=%b %0d,%0d want v=0 0,0", out_valid, out0r, out0i); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        n_vec++; if (stale != 0) begin n_err++; $display("FAIL mid_stale: got %0d stale beats want 0", stale); end
        set_in(1000, 0, 1000, 0, 1000, 0, 1000, 0, 32767, 0, 1'b0);
        push_one(lat);
        $display("post-reset dc: lat=%0d out0r=%0d", lat, out0r);
        n_vec++; if (lat != 3 || out0r !== 16'sd1000) begin n_err++; $display("FAIL mid_recover: got lat=%0d %0d want lat=3 1000", lat, out0r); end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_dc();
        test_impulse();
        test_mode();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
